// File: rtl/dso_pkg.sv
// Shared DSO types: dump FSM states and the channel-select encoding used by the
// capture SM, RAM interface and dump SM.
package dso_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_SEND,
    ST_TXWAIT,
    ST_DONE
  } dump_state_t;

  localparam logic [1:0] CH_NONE = 2'b00;
  localparam logic [1:0] CH1     = 2'b01;
  localparam logic [1:0] CH2     = 2'b10;
  localparam logic [1:0] CH3     = 2'b11;

endpackage

// File: rtl/dump_sm_wrap_counter.sv
// Combinational modulo-DEPTH incrementer; tc_o flags the last value (DEPTH-1).
// No state, no latency, no flow control: the caller decides when to take next_o.
module wrap_counter #(
  parameter int DEPTH = 384,
  parameter int W     = 9
) (
  input  logic [W-1:0] value_i,
  output logic [W-1:0] next_o,
  output logic         tc_o
);

  assign tc_o   = (value_i == W'(DEPTH - 1));
  assign next_o = tc_o ? '0 : value_i + 1'b1;

endmodule

// File: rtl/dump_sm.sv
// Walks one channel's circular capture buffer from the oldest sample and feeds each
// byte to the UART; per sample 2+RD_LAT cycles plus the wait for tx_done.
module dump_sm
  import dso_pkg::*;
#(
  parameter int DEPTH  = 384,
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_start,
  input  logic [1:0]        dump_chan,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic [7:0]        read_data,
  input  logic              tx_done,
  output logic              dump_en,
  output logic [1:0]        ch_sel,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  dump_state_t       state_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [LAT_W-1:0]  lat_q;
  logic [1:0]        ch_sel_q;
  logic [7:0]        tx_data_q;
  logic              dump_en_q, tx_start_q, busy_q, done_q;
  logic              cnt_last;
  logic              addr_wrap_unused;

  wrap_counter #(.DEPTH(DEPTH), .W(ADDR_W)) u_addr_ctr (
    .value_i (addr_q),
    .next_o  (addr_d),
    .tc_o    (addr_wrap_unused)
  );

  wrap_counter #(.DEPTH(DEPTH), .W(ADDR_W)) u_cnt_ctr (
    .value_i (cnt_q),
    .next_o  (cnt_d),
    .tc_o    (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      lat_q      <= '0;
      ch_sel_q   <= CH_NONE;
      tx_data_q  <= 8'h00;
      dump_en_q  <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      dump_en_q  <= 1'b0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (dump_start && (dump_chan != CH_NONE)) begin
            ch_sel_q  <= dump_chan;
            addr_q    <= trig_pos;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            dump_en_q <= 1'b1;
            state_q   <= ST_READ;
          end
        end
        ST_READ: begin
          lat_q   <= '0;
          state_q <= ST_WAIT;
        end
        // read_data is valid exactly RD_LAT cycles after the dump_en cycle
        ST_WAIT: begin
          if (lat_q == LAT_W'(RD_LAT - 1)) begin
            tx_data_q  <= read_data;
            tx_start_q <= 1'b1;
            state_q    <= ST_SEND;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        ST_SEND: state_q <= ST_TXWAIT;
        ST_TXWAIT: begin
          if (tx_done) begin
            if (cnt_last) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              cnt_q     <= cnt_d;
              addr_q    <= addr_d;
              dump_en_q <= 1'b1;
              state_q   <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          busy_q   <= 1'b0;
          ch_sel_q <= CH_NONE;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dump_en   = dump_en_q;
  assign ch_sel    = ch_sel_q;
  assign addr      = addr_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign dump_busy = busy_q;
  assign dump_done = done_q;

endmodule
